// File: rtl/instruction_encoder.sv
// RV32I field-to-word encoder with LI expansion into LUI+ADDI and immediate range checking.
// Latency 1 cycle; single registered output stage, in_ready drops while the output is stalled or an LI tail is pending.
module instruction_encoder #(
  parameter int ILEN        = 32,
  parameter int XLEN        = 32,
  parameter bit RANGE_CHECK = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_fmt,
  input  logic [6:0]      in_opcode,
  input  logic [4:0]      in_rd,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [2:0]      in_funct3,
  input  logic [6:0]      in_funct7,
  input  logic [XLEN-1:0] in_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_instr,
  output logic            out_last,
  output logic            err
);

  localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3,
                         FMT_U = 3'd4, FMT_J = 3'd5, FMT_LI = 3'd6;
  localparam logic [6:0] OP_IMM = 7'b0010011, OP_LUI = 7'b0110111;

  typedef enum logic {IDLE, SECOND} state_t;

  state_t      state, state_nxt;
  logic        valid_nxt, last_nxt, err_nxt;
  logic [31:0] instr_nxt;
  logic [4:0]  pend_rd, pend_rd_nxt;
  logic [11:0] pend_lo, pend_lo_nxt;

  logic [31:0] imm, li_sum, enc;
  logic [19:0] li_hi;
  logic        fits12, fits13, fits21, bad, out_free, accept;

  assign imm    = in_imm[31:0];
  assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits21 = (&imm[31:20]) | ~(|imm[31:20]);
  // Rounding up by 0x800 compensates for ADDI sign-extending its 12-bit low part.
  assign li_sum = imm + 32'h0000_0800;
  assign li_hi  = li_sum[31:12];

  always_comb begin
    bad = 1'b0;
    enc = '0;
    case (in_fmt)
      FMT_R: enc = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      FMT_I: begin
        enc = {imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        bad = RANGE_CHECK && !fits12;
      end
      FMT_S: begin
        enc = {imm[11:5], in_rs2, in_rs1, in_funct3, imm[4:0], in_opcode};
        bad = RANGE_CHECK && !fits12;
      end
      FMT_B: begin
        enc = {imm[12], imm[10:5], in_rs2, in_rs1, in_funct3, imm[4:1], imm[11], in_opcode};
        bad = RANGE_CHECK && (!fits13 || imm[0]);
      end
      FMT_U: begin
        enc = {imm[31:12], in_rd, in_opcode};
        bad = RANGE_CHECK && (imm[11:0] != 12'd0);
      end
      FMT_J: begin
        enc = {imm[20], imm[10:1], imm[11], imm[19:12], in_rd, in_opcode};
        bad = RANGE_CHECK && (!fits21 || imm[0]);
      end
      FMT_LI: begin
        if (fits12) enc = {imm[11:0], 5'd0, 3'b000, in_rd, OP_IMM};
        else        enc = {li_hi, in_rd, OP_LUI};
      end
      default: bad = 1'b1;
    endcase
  end

  assign out_free = !out_valid || out_ready;
  assign in_ready = !reset && (state == IDLE) && out_free;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_nxt   = state;
    valid_nxt   = out_valid && !out_ready;
    instr_nxt   = out_instr;
    last_nxt    = out_last;
    err_nxt     = 1'b0;
    pend_rd_nxt = pend_rd;
    pend_lo_nxt = pend_lo;
    case (state)
      SECOND: begin
        if (out_free) begin
          valid_nxt = 1'b1;
          instr_nxt = {pend_lo, pend_rd, 3'b000, pend_rd, OP_IMM};
          last_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        if (accept) begin
          if (bad) begin
            err_nxt = 1'b1;
          end else begin
            valid_nxt = 1'b1;
            instr_nxt = enc;
            last_nxt  = 1'b1;
            if (in_fmt == FMT_LI && !fits12 && imm[11:0] != 12'd0) begin
              last_nxt    = 1'b0;
              state_nxt   = SECOND;
              pend_rd_nxt = in_rd;
              pend_lo_nxt = imm[11:0];
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_last  <= 1'b0;
      err       <= 1'b0;
      pend_rd   <= '0;
      pend_lo   <= '0;
    end else begin
      state     <= state_nxt;
      out_valid <= valid_nxt;
      out_instr <= instr_nxt;
      out_last  <= last_nxt;
      err       <= err_nxt;
      pend_rd   <= pend_rd_nxt;
      pend_lo   <= pend_lo_nxt;
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench for instruction_encoder: directed vectors push expected words/errors, a monitor pops on each output event.
module tb_instruction_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_last;
  logic        err;

  instruction_encoder #(.ILEN(32), .XLEN(32), .RANGE_CHECK(1'b1)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_last(out_last), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_err;
    logic        last;
    logic [31:0] instr;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] instr, input logic last);
    exp_t e;
    e.is_err = 1'b0; e.last = last; e.instr = instr;
    q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1; e.last = 1'b0; e.instr = '0;
    q.push_back(e);
  endtask

  // Monitor: every word handshake or err pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_word", out_instr, 32'hxxxx_xxxx);
        end else begin
          e = q.pop_front();
          check("word_kind", {31'd0, e.is_err}, 32'd0);
          check("word_instr", out_instr, e.instr);
          check("word_last", {31'd0, out_last}, {31'd0, e.last});
        end
      end
      if (err) begin
        if (q.size() == 0) begin
          check("unexpected_err", {31'd0, err}, 32'd0);
        end else begin
          e = q.pop_front();
          check("err_kind", {31'd0, e.is_err}, 32'd1);
        end
      end
    end
  end

  task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic wait_accept();
    int n = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        check("accept_timeout", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // chk: 0 none, 1 word one cycle later with given last, 2 err pulse one cycle later
  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm, input int chk, input logic last);
    drive(fmt, op, rd, rs1, rs2, f3, f7, imm);
    wait_accept();
    if (chk != 0) begin
      @(negedge clk);
      if (chk == 1) begin
        check("latency_valid", {31'd0, out_valid}, 32'd1);
        check("latency_last", {31'd0, out_last}, {31'd0, last});
      end else begin
        check("err_pulse", {31'd0, err}, 32'd1);
        check("err_no_valid", {31'd0, out_valid}, 32'd0);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Decoder-inverse words
    push_word(32'h010cc783, 1'b1); send(3'd1, 7'b0000011, 5'd15, 5'd25, 5'd0, 3'b100, 7'd0, 32'd16, 1, 1'b1);
    push_word(32'h02912a23, 1'b1); send(3'd2, 7'b0100011, 5'd0, 5'd2, 5'd9, 3'b010, 7'd0, 32'd52, 1, 1'b1);
    push_word(32'hfed79ce3, 1'b1); send(3'd3, 7'b1100011, 5'd0, 5'd15, 5'd13, 3'b001, 7'd0, -32'sd8, 1, 1'b1);
    push_word(32'h00001cb7, 1'b1); send(3'd4, 7'b0110111, 5'd25, 5'd0, 5'd0, 3'b000, 7'd0, 32'h1000, 1, 1'b1);
    push_word(32'h002081b3, 1'b1); send(3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0, 1, 1'b1);
    push_word(32'h001000ef, 1'b1); send(3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'h800, 1, 1'b1);

    // LI split: in_ready must be low while the tail word is pending
    push_word(32'h12345537, 1'b0); push_word(32'h67850513, 1'b1);
    drive(3'd6, 7'd0, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345678);
    wait_accept();
    @(negedge clk);
    check("li_in_ready_low", {31'd0, in_ready}, 32'd0);
    check("li_first_last", {31'd0, out_last}, 32'd0);
    drain();
    push_word(32'h12346537, 1'b0); push_word(32'hfff50513, 1'b1);
    send(3'd6, 7'd0, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345fff, 1, 1'b0);
    drain();
    push_word(32'hfff00513, 1'b1); send(3'd6, 7'd0, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'hffffffff, 1, 1'b1);
    push_word(32'h00005537, 1'b1); send(3'd6, 7'd0, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00005000, 1, 1'b1);
    drain();

    // Errors, then a clean request
    push_err(); send(3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd3, 2, 1'b0);
    push_err(); send(3'd1, 7'b0010011, 5'd1, 5'd1, 5'd0, 3'b000, 7'd0, 32'd2048, 2, 1'b0);
    push_err(); send(3'd7, 7'd0, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd0, 2, 1'b0);
    push_err(); send(3'd4, 7'b0110111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'h1001, 2, 1'b0);
    push_word(32'h010cc783, 1'b1); send(3'd1, 7'b0000011, 5'd15, 5'd25, 5'd0, 3'b100, 7'd0, 32'd16, 1, 1'b1);
    drain();

    // Backpressure: output stalled five cycles with a request waiting
    out_ready = 1'b0;
    push_word(32'h02912a23, 1'b1); send(3'd2, 7'b0100011, 5'd0, 5'd2, 5'd9, 3'b010, 7'd0, 32'd52, 0, 1'b0);
    push_word(32'hfed79ce3, 1'b1); drive(3'd3, 7'b1100011, 5'd0, 5'd15, 5'd13, 3'b001, 7'd0, -32'sd8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_out_instr", out_instr, 32'h02912a23);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_accept();
    push_word(32'h00001cb7, 1'b1); send(3'd4, 7'b0110111, 5'd25, 5'd0, 5'd0, 3'b000, 7'd0, 32'h1000, 0, 1'b0);
    drain();

    // Reset while the LI tail is pending drops it
    out_ready = 1'b0;
    send(3'd6, 7'd0, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345678, 0, 1'b0);
    reset = 1'b1;
    q.delete();
    @(negedge clk);
    check("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_err", {31'd0, err}, 32'd0);
    @(posedge clk);
    #1;
    push_word(32'h002081b3, 1'b1); send(3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0, 1, 1'b1);
    drain();
    repeat (3) @(posedge clk);
    check("scoreboard_empty", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
